// File: rtl/conv_tap_sequencer_pkg.sv
// Shared types and B-bus select codes for the 3x3 convolution tap sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH_K = 2'd1,
    ST_FETCH_P = 2'd2,
    ST_WRITE   = 2'd3
  } conv_state_e;

  localparam logic [4:0] SEL_NONE = 5'b00000;
  localparam logic [4:0] SEL_K0   = 5'b00010;
  localparam logic [4:0] SEL_P1   = 5'b01011;
  localparam logic [4:0] SEL_CV   = 5'b01111;

  localparam int unsigned NUM_TAPS = 9;
  localparam logic [3:0]  LAST_TAP = 4'(NUM_TAPS - 1);

endpackage

// File: rtl/conv_tap_sequencer_mac.sv
// Signed kernel x unsigned pixel multiply with a 32-bit wrapping accumulator.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int KERN_W = 8,
  parameter int PIX_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [KERN_W-1:0] kern,
  input  logic        [PIX_W-1:0]  pix,
  output logic        [31:0]       acc
);

  localparam int PROD_W = KERN_W + PIX_W + 1;

  logic signed [PIX_W:0]    pix_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [31:0]       prod_ext;

  // Pixel gets a zero sign bit so the multiply stays fully signed.
  assign pix_s    = $signed({1'b0, pix});
  assign prod     = PROD_W'(kern) * PROD_W'(pix_s);
  assign prod_ext = 32'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/conv_tap_sequencer.sv
// Walks the nine taps over the shared B-bus and writes one convolution result to CV.
// Optional CONV_SAT_EN clamps the written result to the pixel range.
//
// state    | meaning
// IDLE     | bus released (select 0), waiting for start
// FETCH_K  | select K<tap>, latch kernel coefficient
// FETCH_P  | select pixel row of tap, multiply-accumulate
// WRITE    | present result, pulse cv_we/done
module conv_tap_sequencer
  import conv_pkg::*;
#(
  parameter int KERN_W = 8,
  parameter int PIX_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bus_in,
  output logic [4:0]  bus_sel,
  output logic        busy,
  output logic [3:0]  tap_idx,
  output logic        cv_we,
  output logic [31:0] cv_data,
  output logic        done
);

  conv_state_e state, state_nxt;

  logic [3:0]               tap;
  logic [1:0]               row;
  logic [1:0]               col;
  logic signed [KERN_W-1:0] kern_q;
  logic [PIX_W-1:0]         pix;
  logic                     mac_clr;
  logic                     mac_en;
  logic                     kern_ld;
  logic [31:0]              acc;
  logic [31:0]              result;
  logic [31:0]              cv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_sel   = SEL_NONE;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    kern_ld   = 1'b0;
    cv_we     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          mac_clr   = 1'b1;
          state_nxt = ST_FETCH_K;
        end
      end
      ST_FETCH_K: begin
        bus_sel   = SEL_K0 + {1'b0, tap};
        kern_ld   = 1'b1;
        state_nxt = ST_FETCH_P;
      end
      ST_FETCH_P: begin
        bus_sel   = SEL_P1 + {3'b000, row};
        mac_en    = 1'b1;
        state_nxt = (tap == LAST_TAP) ? ST_WRITE : ST_FETCH_K;
      end
      ST_WRITE: begin
        cv_we     = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap <= '0;
    end else if ((state == ST_IDLE && start) || state == ST_WRITE) begin
      tap <= '0;
    end else if (state == ST_FETCH_P && tap != LAST_TAP) begin
      tap <= tap + 4'd1;
    end
  end

  always_comb begin
    row = 2'd0;
    col = 2'd0;
    case (tap)
      4'd0: begin row = 2'd0; col = 2'd0; end
      4'd1: begin row = 2'd0; col = 2'd1; end
      4'd2: begin row = 2'd0; col = 2'd2; end
      4'd3: begin row = 2'd1; col = 2'd0; end
      4'd4: begin row = 2'd1; col = 2'd1; end
      4'd5: begin row = 2'd1; col = 2'd2; end
      4'd6: begin row = 2'd2; col = 2'd0; end
      4'd7: begin row = 2'd2; col = 2'd1; end
      4'd8: begin row = 2'd2; col = 2'd2; end
      default: begin row = 2'd0; col = 2'd0; end
    endcase
  end

  always_comb begin
    pix = bus_in[PIX_W-1:0];
    case (col)
      2'd1:    pix = bus_in[PIX_W +: PIX_W];
      2'd2:    pix = bus_in[2*PIX_W +: PIX_W];
      default: pix = bus_in[PIX_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       kern_q <= '0;
    else if (kern_ld) kern_q <= bus_in[KERN_W-1:0];
  end

  conv_mac_unit #(
    .KERN_W(KERN_W),
    .PIX_W (PIX_W)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .kern (kern_q),
    .pix  (pix),
    .acc  (acc)
  );

`ifdef CONV_SAT_EN
  localparam logic [31:0] PIX_MAX = (32'd1 << PIX_W) - 32'd1;

  always_comb begin
    result = acc;
    if (acc[31])            result = '0;
    else if (acc > PIX_MAX) result = PIX_MAX;
  end
`else
  assign result = acc;
`endif

  // acc is cleared by the next start, so the written value is held separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cv_q <= '0;
    else if (state == ST_WRITE) cv_q <= result;
  end

  assign cv_data = (state == ST_WRITE) ? result : cv_q;
  assign busy    = (state != ST_IDLE);
  assign tap_idx = tap;

  generate
    if (3 * PIX_W < 32) begin : g_unused_bus
      logic unused_bus;
      assign unused_bus = ^bus_in[31:3*PIX_W];
    end
  endgenerate

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Scoreboard bench for conv_tap_sequencer with a behavioural B-bus mux.
module tb_conv_tap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bus_in;
  logic [4:0]  bus_sel;
  logic        busy;
  logic [3:0]  tap_idx;
  logic        cv_we;
  logic [31:0] cv_data;
  logic        done;

  logic [31:0] k_reg [9];
  logic [31:0] prow  [3];
  logic [31:0] exp_q [$];

  int checks;
  int failures;

`ifdef CONV_SAT_EN
  localparam logic [31:0] EXP_NEG = 32'd0;
  localparam logic [31:0] EXP_BIG = 32'd255;
  localparam logic [31:0] EXP_K0  = 32'd255;
`else
  localparam logic [31:0] EXP_NEG = 32'hFFFFF709;
  localparam logic [31:0] EXP_BIG = 32'd291465;
  localparam logic [31:0] EXP_K0  = 32'd765;
`endif

  conv_tap_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus_in (bus_in),
    .bus_sel(bus_sel),
    .busy   (busy),
    .tap_idx(tap_idx),
    .cv_we  (cv_we),
    .cv_data(cv_data),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus_in = '0;
    if (bus_sel >= 5'd2 && bus_sel <= 5'd10)       bus_in = k_reg[int'(bus_sel) - 2];
    else if (bus_sel >= 5'd11 && bus_sel <= 5'd13) bus_in = prow[int'(bus_sel) - 11];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (cv_we || done)) begin
      chk("done_with_we", {30'd0, done, cv_we}, 32'd3);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        chk("cv_data", cv_data, exp_q.pop_front());
      end
    end
  end

  task automatic set_k(input logic [31:0] v);
    for (int i = 0; i < 9; i++) k_reg[i] = v;
  endtask

  task automatic set_p(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    prow[0] = p1; prow[1] = p2; prow[2] = p3;
  endtask

  function automatic logic [4:0] exp_sel(input int cyc);
    int t;
    t = (cyc - 1) / 2;
    if (cyc > 18)          return 5'h00;
    else if (cyc % 2 == 1) return 5'(5'h02 + t);
    else                   return 5'(5'h0B + t / 3);
  endfunction

  task automatic run_conv(input logic [31:0] exp, input int pa, input int pb,
                          input bit hold, input bit pre);
    exp_q.push_back(exp);
    if (!pre) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      start = hold || cyc == pa || cyc == pb;
      @(negedge clk);
      chk($sformatf("bus_sel_c%0d", cyc), {27'd0, bus_sel}, {27'd0, exp_sel(cyc)});
      chk($sformatf("busy_c%0d", cyc), {31'd0, busy}, {31'd0, cyc <= 19});
      chk($sformatf("cv_we_c%0d", cyc), {31'd0, cv_we}, {31'd0, cyc == 19});
      if (cyc <= 18) chk($sformatf("tap_c%0d", cyc), {28'd0, tap_idx}, 32'((cyc - 1) / 2));
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_sel", {27'd0, bus_sel}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},    32'd0);
    chk({tag, "_done"},  {31'd0, done},    32'd0);
    chk({tag, "_cv_we"}, {31'd0, cv_we},   32'd0);
    chk({tag, "_cv"},    cv_data,          32'd0);
    chk({tag, "_tap"},   {28'd0, tap_idx}, 32'd0);
    chk({tag, "_sel"},   {27'd0, bus_sel}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0;
    set_k(32'd0); set_p(32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all K=1, rows of 10s -> 90
    set_k(32'd1); set_p(32'h000A0A0A, 32'h000A0A0A, 32'h000A0A0A);
    run_conv(32'd90, 0, 0, 1'b0, 1'b0);
    idle_check(2);
    chk("cv_hold", cv_data, 32'd90);

    // identity kernel picks centre pixel of P2
    set_k(32'd0); k_reg[4] = 32'd1; set_p(32'h00FFFFFF, 32'h00302010, 32'h00FFFFFF);
    run_conv(32'h20, 0, 0, 1'b0, 1'b0);

    // all K=-1, all pixels 255
    set_k(32'h000000FF); set_p(32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF);
    run_conv(EXP_NEG, 0, 0, 1'b0, 1'b0);

    // all K=127, all pixels 255
    set_k(32'h0000007F);
    run_conv(EXP_BIG, 0, 0, 1'b0, 1'b0);

    // only K0=3 on pixel 255 -> 765
    set_k(32'd0); k_reg[0] = 32'd3; set_p(32'h000000FF, 32'd0, 32'd0);
    run_conv(EXP_K0, 0, 0, 1'b0, 1'b0);

    // start pulses mid-run and in WRITE are ignored
    set_k(32'd1); set_p(32'h000A0A0A, 32'h000A0A0A, 32'h000A0A0A);
    run_conv(32'd90, 5, 19, 1'b0, 1'b0);
    idle_check(3);

    // start held high: second run begins with FETCH_K in cycle 21
    run_conv(32'd90, 0, 0, 1'b1, 1'b0);
    run_conv(32'd90, 0, 0, 1'b0, 1'b1);
    idle_check(1);

    // reset in cycle 10 aborts the run without a write
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    @(negedge clk);
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check(3);

    set_k(32'd2); set_p(32'h00010203, 32'h00010203, 32'h00010203);
    run_conv(32'd36, 0, 0, 1'b0, 1'b0);
    idle_check(2);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
